gen_reg_bank: RTL and testbench

//  Parametrised register bank behind the 32-bit addr_ctrl/data bus from the host interface.

---
 rtl/gen_reg_bank.sv | 140 ++++++++++++++
 tb/tb_gen_reg_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_reg_bank.sv
// gen_reg_bank: host-bus register bank with N_WR read/write registers,
// N_RD registered status inputs and one self-clearing pulse register.
//
// Handshake: an access starts on the rising edge of addr_ctrl[0] (select).
// Address, direction and data are sampled in that cycle only. Exactly one
// cycle later ack pulses high for a single cycle. err and data_out update
// together with ack and hold until the next ack. Select must drop for at
// least one cycle before the next access is recognised.
module gen_reg_bank #(
  parameter int              DW        = 32,
  parameter int              N_WR      = 4,
  parameter int              N_RD      = 4,
  parameter logic [15:0]     BASE_ADDR = 16'h0000,
  parameter logic [DW-1:0]   RST_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr_ctrl,
  input  logic [DW-1:0]        data_in,
  output logic [DW-1:0]        data_out,
  output logic                 ack,
  output logic                 err,
  output logic [N_WR*DW-1:0]   wr_regs,
  input  logic [N_RD*DW-1:0]   rd_regs,
  output logic [N_WR-1:0]      wr_strobe,
  output logic [DW-1:0]        pulse_out,
  output logic [7:0]           debug
);

  logic                         sel_q, sel_d;
  logic [N_WR-1:0][DW-1:0]      wr_q, wr_d;
  logic [N_RD-1:0][DW-1:0]      stat_q, stat_d;
  logic [DW-1:0]                data_out_q, data_out_d;
  logic                         ack_q, ack_d;
  logic                         err_q, err_d;
  logic [N_WR-1:0]              wr_strobe_q, wr_strobe_d;
  logic [DW-1:0]                pulse_q, pulse_d;

  logic                         access;
  logic                         is_read;
  logic [15:0]                  idx;
  logic                         hit_rw, hit_ro, hit_pulse;
  logic [N_WR-1:0]              rw_sel;
  logic [DW-1:0]                rd_val;
  logic                         unused_addr_bits;

  // Address bits between the control bits and the address field carry nothing.
  assign unused_addr_bits = ^addr_ctrl[15:2];

  // Access is the select rising edge; sel_q resets high so a select held
  // through reset release is not mistaken for a new access.
  assign sel_d   = addr_ctrl[0];
  assign access  = addr_ctrl[0] & ~sel_q;
  assign is_read = addr_ctrl[1];
  assign stat_d  = rd_regs;

  // Decode the 16-bit index (wraps modulo 2^16) and pick the read value.
  always_comb begin
    idx       = addr_ctrl[31:16] - BASE_ADDR;
    hit_rw    = 1'b0;
    hit_ro    = 1'b0;
    rw_sel    = '0;
    rd_val    = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (idx == 16'(i)) begin
        hit_rw    = 1'b1;
        rw_sel[i] = 1'b1;
        rd_val    = wr_q[i];
      end
    end
    for (int j = 0; j < N_RD; j++) begin
      if (idx == 16'(N_WR + j)) begin
        hit_ro = 1'b1;
        rd_val = stat_q[j];
      end
    end
    hit_pulse = (idx == 16'(N_WR + N_RD));
  end

  // Next-state for registers, strobes, ack/err and read data.
  always_comb begin
    wr_d        = wr_q;
    wr_strobe_d = '0;
    pulse_d     = '0;
    ack_d       = 1'b0;
    err_d       = err_q;
    data_out_d  = data_out_q;
    if (access) begin
      ack_d = 1'b1;
      if (is_read) begin
        // Pulse register reads as zero; unmapped reads return zero with err.
        data_out_d = rd_val;
        err_d      = ~(hit_rw | hit_ro | hit_pulse);
      end else begin
        err_d = ~(hit_rw | hit_pulse);
        for (int i = 0; i < N_WR; i++) begin
          if (rw_sel[i]) begin
            wr_d[i]        = data_in;
            wr_strobe_d[i] = 1'b1;
          end
        end
        if (hit_pulse) begin
          pulse_d = data_in;
        end
      end
    end
  end

  // State registers; reset clears any pending ack/strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= 1'b1;
      wr_q        <= {N_WR{RST_VAL}};
      stat_q      <= '0;
      data_out_q  <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      wr_strobe_q <= '0;
      pulse_q     <= '0;
    end else begin
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      stat_q      <= stat_d;
      data_out_q  <= data_out_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      wr_strobe_q <= wr_strobe_d;
      pulse_q     <= pulse_d;
    end
  end

  assign wr_regs   = wr_q;
  assign data_out  = data_out_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign wr_strobe = wr_strobe_q;
  assign pulse_out = pulse_q;
  assign debug     = {3'b000, access, err_q, ack_q, sel_q, addr_ctrl[0]};

endmodule

// File: tb/tb_gen_reg_bank.sv
// Bench for gen_reg_bank: directed scenarios with literal expectations plus
// randomized bus traffic, all compared every cycle against a behavioural model.
module tb_gen_reg_bank;

  localparam int          DW   = 32;
  localparam int          NW   = 4;
  localparam int          NR   = 4;
  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [31:0] RV   = 32'hA5A5_0000;

  logic               clk;
  logic               reset;
  logic [31:0]        addr_ctrl;
  logic [DW-1:0]      data_in;
  logic [DW-1:0]      data_out;
  logic               ack;
  logic               err;
  logic [NW*DW-1:0]   wr_regs;
  logic [NR*DW-1:0]   rd_regs;
  logic [NW-1:0]      wr_strobe;
  logic [DW-1:0]      pulse_out;
  logic [7:0]         debug;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  gen_reg_bank #(
    .DW(DW), .N_WR(NW), .N_RD(NR), .BASE_ADDR(BASE), .RST_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .addr_ctrl(addr_ctrl), .data_in(data_in),
    .data_out(data_out), .ack(ack), .err(err), .wr_regs(wr_regs),
    .rd_regs(rd_regs), .wr_strobe(wr_strobe), .pulse_out(pulse_out),
    .debug(debug)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [DW-1:0] m_regs [NW];
  logic [DW-1:0] m_stat [NR];
  logic [DW-1:0] m_dout, m_pulse;
  logic          m_ack, m_err, m_sel;
  logic [NW-1:0] m_strobe;

  always begin : model
    logic        acc;
    logic [15:0] off;
    int          idx;
    logic [NW*DW-1:0] exp_regs;
    logic [7:0]  exp_dbg;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NW; i++) m_regs[i] = RV;
      for (int j = 0; j < NR; j++) m_stat[j] = '0;
      m_dout = '0; m_pulse = '0; m_ack = 1'b0; m_err = 1'b0;
      m_strobe = '0; m_sel = 1'b1;
    end else begin
      acc = addr_ctrl[0] && !m_sel;
      m_ack = 1'b0; m_strobe = '0; m_pulse = '0;
      if (acc) begin
        off = addr_ctrl[31:16] - BASE;
        idx = int'(off);
        m_ack = 1'b1;
        if (addr_ctrl[1]) begin
          if (idx < NW)            begin m_dout = m_regs[idx];     m_err = 1'b0; end
          else if (idx < NW + NR)  begin m_dout = m_stat[idx - NW]; m_err = 1'b0; end
          else if (idx == NW + NR) begin m_dout = '0;              m_err = 1'b0; end
          else                     begin m_dout = '0;              m_err = 1'b1; end
        end else begin
          if (idx < NW) begin
            m_regs[idx] = data_in; m_strobe[idx] = 1'b1; m_err = 1'b0;
          end else if (idx == NW + NR) begin
            m_pulse = data_in; m_err = 1'b0;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      for (int j = 0; j < NR; j++) m_stat[j] = rd_regs[j*DW +: DW];
      m_sel = addr_ctrl[0];
    end
    #1;
    for (int i = 0; i < NW; i++) exp_regs[i*DW +: DW] = m_regs[i];
    exp_dbg = {3'b000, addr_ctrl[0] & ~m_sel, m_err, m_ack, m_sel, addr_ctrl[0]};
    if (ack) ack_cnt++;
    chk("cyc_ack",       128'(ack),       128'(m_ack));
    chk("cyc_err",       128'(err),       128'(m_err));
    chk("cyc_data_out",  128'(data_out),  128'(m_dout));
    chk("cyc_wr_regs",   128'(wr_regs),   128'(exp_regs));
    chk("cyc_wr_strobe", 128'(wr_strobe), 128'(m_strobe));
    chk("cyc_pulse_out", 128'(pulse_out), 128'(m_pulse));
    chk("cyc_debug",     128'(debug),     128'(exp_dbg));
  end

  // ---------------- driver tasks ----------------
  task automatic start(input logic rw, input logic [15:0] a, input logic [DW-1:0] d);
    addr_ctrl = {a, 14'h0, rw, 1'b1};
    data_in   = d;
    @(negedge clk);
  endtask

  task automatic drop();
    addr_ctrl[0] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int a0;
    logic [NW*DW-1:0] saved;
    logic [15:0] ra;
    reset     = 1'b0;
    addr_ctrl = 32'h0000_0001;
    data_in   = '0;
    rd_regs   = '0;
    repeat (3) @(negedge clk);

    // 1: release reset with select held high
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_ack",  128'(ack_cnt), 128'(0));
    chk("rst_wr_regs", 128'(wr_regs), 128'({4{32'hA5A5_0000}}));
    chk("rst_sel_q",   128'(debug[1]), 128'(1));
    chk("rst_dout",    128'(data_out), 128'(0));
    drop();

    // 2: write then read back idx 2
    start(1'b0, BASE + 16'd2, 32'hDEADBEEF);
    chk("wr2_strobe", 128'(wr_strobe), 128'(4'b0100));
    chk("wr2_ack",    128'(ack), 128'(1));
    chk("wr2_err",    128'(err), 128'(0));
    chk("wr2_reg",    128'(wr_regs[2*DW +: DW]), 128'(32'hDEADBEEF));
    drop();
    chk("wr2_ack_off",    128'(ack), 128'(0));
    chk("wr2_strobe_off", 128'(wr_strobe), 128'(0));
    start(1'b1, BASE + 16'd2, 32'h0);
    chk("rd2_data", 128'(data_out), 128'(32'hDEADBEEF));
    chk("rd2_ack",  128'(ack), 128'(1));
    drop();

    // 3: select held high 10 cycles, changes ignored
    a0 = ack_cnt;
    start(1'b0, BASE, 32'h11);
    repeat (4) @(negedge clk);
    data_in = 32'h99;
    addr_ctrl[31:16] = BASE + 16'd1;
    addr_ctrl[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_one_ack", 128'(ack_cnt - a0), 128'(1));
    chk("hold_reg0",    128'(wr_regs[DW-1:0]), 128'(32'h11));
    drop();
    start(1'b0, BASE + 16'd1, 32'h22);
    chk("hold_second_ack", 128'(ack_cnt - a0), 128'(2));
    drop();

    // 4: status read, then write to read-only
    rd_regs[1*DW +: DW] = 32'h12345678;
    repeat (2) @(negedge clk);
    start(1'b1, BASE + 16'(NW + 1), 32'h0);
    chk("ro_rd_data", 128'(data_out), 128'(32'h12345678));
    chk("ro_rd_err",  128'(err), 128'(0));
    drop();
    saved = wr_regs;
    start(1'b0, BASE + 16'(NW + 1), 32'hFFFF);
    chk("ro_wr_ack",  128'(ack), 128'(1));
    chk("ro_wr_err",  128'(err), 128'(1));
    chk("ro_wr_regs", 128'(wr_regs), 128'(saved));
    chk("ro_wr_dout", 128'(data_out), 128'(32'h12345678));
    drop();
    chk("err_held", 128'(err), 128'(1));

    // 5: pulse register and unmapped addresses
    start(1'b0, BASE + 16'(NW + NR), 32'h5);
    chk("pulse_on",  128'(pulse_out), 128'(32'h5));
    drop();
    chk("pulse_off", 128'(pulse_out), 128'(0));
    start(1'b1, BASE + 16'(NW + NR), 32'h0);
    chk("pulse_rd",     128'(data_out), 128'(0));
    chk("pulse_rd_err", 128'(err), 128'(0));
    drop();
    start(1'b0, BASE + 16'h100, 32'h1);
    chk("unmap_hi_ack", 128'(ack), 128'(1));
    chk("unmap_hi_err", 128'(err), 128'(1));
    drop();
    start(1'b1, BASE - 16'd1, 32'h0);
    chk("unmap_lo_err",  128'(err), 128'(1));
    chk("unmap_lo_data", 128'(data_out), 128'(0));
    drop();

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 2) == 0) rd_regs = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 3) ra = 16'($urandom);
      else ra = BASE + 16'($urandom_range(0, NW + NR + 1));
      start(1'($urandom_range(0, 1)), ra, $urandom);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        if ($urandom_range(0, 1) == 1) begin
          data_in = $urandom;
          addr_ctrl[31:16] = 16'($urandom);
        end
        @(negedge clk);
      end
      drop();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // 6: reset right after a write access
    start(1'b0, BASE + 16'd3, 32'h77);
    chk("rst6_strobe_pre", 128'(wr_strobe), 128'(4'b1000));
    reset = 1'b0;
    #1;
    chk("rst6_ack",    128'(ack), 128'(0));
    chk("rst6_strobe", 128'(wr_strobe), 128'(0));
    chk("rst6_regs",   128'(wr_regs), 128'({4{32'hA5A5_0000}}));
    addr_ctrl = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    start(1'b0, BASE + 16'(NW + NR), 32'hF0F0);
    chk("rst6_pulse_pre", 128'(pulse_out), 128'(32'hF0F0));
    reset = 1'b0;
    #1;
    chk("rst6_pulse", 128'(pulse_out), 128'(0));
    chk("rst6_ack2",  128'(ack), 128'(0));
    addr_ctrl = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
